// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 256;

    // Requester indices; also the encoding of the last-grant flop.
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arbState_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: a lone request wins outright, a conflict
// goes to the port that was not granted last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_lastGrant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = {i_req1, i_req0};
        if (i_req0 && i_req1) begin
            o_grant = (i_lastGrant == P1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port cache-line memory arbiter sequencing IDLE -> BUSY -> GAP.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise p1 always wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [1:0]        grant_o
);

    arbState_t         r_state;
    arbState_t         w_nextState;
    logic [1:0]        r_grant;
    logic              r_memWrite;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memData;
    logic [1:0]        w_pick;
    logic              w_lastGrant;
    logic              w_accept;
    logic              w_busy;

    assign w_busy   = (r_state == BUSY);
    assign w_accept = (r_state == IDLE) && (p0_enable_i || p1_enable_i);

    mem_arb_pick u_pick (
        .i_req0      (p0_enable_i),
        .i_req1      (p1_enable_i),
        .i_lastGrant (w_lastGrant),
        .o_grant     (w_pick)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_lastGrant;

    // Resets to P0 so that the first conflict after reset goes to p1.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lastGrant <= P0;
        end else if (w_accept) begin
            r_lastGrant <= w_pick[P1];
        end
    end

    assign w_lastGrant = r_lastGrant;
`else
    assign w_lastGrant = P0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = BUSY;
            BUSY:    if (mem_ack_i) w_nextState = GAP;
            GAP:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The winner's request is captured once; requester inputs are ignored until IDLE again.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_grant    <= 2'b00;
            r_memWrite <= 1'b0;
            r_memAddr  <= '0;
            r_memData  <= '0;
        end else if (w_accept) begin
            r_grant    <= w_pick;
            r_memWrite <= w_pick[P1] ? p1_write_i : p0_write_i;
            r_memAddr  <= w_pick[P1] ? p1_addr_i  : p0_addr_i;
            r_memData  <= w_pick[P1] ? p1_data_i  : p0_data_i;
        end else if (w_busy && mem_ack_i) begin
            r_grant    <= 2'b00;
        end
    end

    assign mem_enable_o = w_busy;
    assign mem_write_o  = r_memWrite;
    assign mem_addr_o   = r_memAddr;
    assign mem_data_o   = r_memData;
    assign grant_o      = r_grant;

    assign p0_ack_o  = mem_ack_i && w_busy && r_grant[P0];
    assign p1_ack_o  = mem_ack_i && w_busy && r_grant[P1];
    assign p0_data_o = r_grant[P0] ? mem_data_i : '0;
    assign p1_data_o = r_grant[P1] ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 10-cycle memory model and a
// transaction-level reference (arbitration rule + reference line store).
module tb_mem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 256;
    localparam int MEM_LINES = 64;
    localparam int MEM_LAT   = 10;
    localparam int MAX_WAIT  = 200;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        int            port;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } expTxn_t;

    logic          clk_i;
    logic          rst_i;
    logic          p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i;
    logic [DW-1:0] p0_data_i, p1_data_i;
    logic          p0_ack_o, p1_ack_o;
    logic [DW-1:0] p0_data_o, p1_data_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_data_i;
    logic [1:0]    grant_o;

    logic          modelAck;
    logic          glitchAck;
    logic [DW-1:0] modelData;
    logic [DW-1:0] modelMem [MEM_LINES];
    logic [DW-1:0] refMem [MEM_LINES];
    int            memCnt;

    int      checks = 0;
    int      errors = 0;
    int      busyCycles = 0;
    int      lastServed = 0;
    bit      gapPending = 0;
    expTxn_t expQ [$];

    mem_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p0_enable_i  (p0_enable_i),
        .p0_write_i   (p0_write_i),
        .p0_addr_i    (p0_addr_i),
        .p0_data_i    (p0_data_i),
        .p0_ack_o     (p0_ack_o),
        .p0_data_o    (p0_data_o),
        .p1_enable_i  (p1_enable_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_ack_o     (p1_ack_o),
        .p1_data_o    (p1_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .grant_o      (grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign mem_ack_i  = modelAck | glitchAck;
    assign mem_data_i = modelData;

    function automatic logic [DW-1:0] initLine(input int i);
        logic [DW-1:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hC0DE_0000 + 32'(i * 8 + k);
        return l;
    endfunction

    function automatic logic [1:0] onehot(input int port);
        return (port == 0) ? 2'b01 : 2'b10;
    endfunction

    // Arbitration rule: fixed build always favours p1, round-robin favours the port not served last.
    function automatic int winnerOf();
        if (!RR_EN) return 1;
        return (lastServed == 0) ? 1 : 0;
    endfunction

    function automatic expTxn_t makeTxn(input int port);
        expTxn_t t;
        t.port  = port;
        t.write = 1'($urandom_range(0, 1));
        t.addr  = 32'($urandom_range(0, MEM_LINES - 1)) << 5;
        for (int k = 0; k < 8; k++) t.data[k*32 +: 32] = $urandom;
        return t;
    endfunction

    // Memory: the enable is first seen one edge after it rises, so the ack lands in the 10th busy cycle.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            modelAck <= 1'b0;
            memCnt   <= 0;
            for (int i = 0; i < MEM_LINES; i++) modelMem[i] <= initLine(i);
        end else if (!mem_enable_o || modelAck) begin
            modelAck <= 1'b0;
            memCnt   <= 0;
        end else if (memCnt == MEM_LAT - 2) begin
            modelAck <= 1'b1;
            memCnt   <= 0;
            if (mem_write_o) modelMem[mem_addr_o[10:5]] <= mem_data_o;
            else             modelData <= modelMem[mem_addr_o[10:5]];
        end else begin
            memCnt <= memCnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per requester ack and updates the reference store.
    always @(negedge clk_i) begin
        expTxn_t t;
        if (!rst_i) begin
            busyCycles = 0;
            gapPending = 0;
            lastServed = 0;
            for (int i = 0; i < MEM_LINES; i++) refMem[i] = initLine(i);
        end else begin
            if (mem_enable_o) busyCycles++;
            else              busyCycles = 0;
            if (gapPending) begin
                checkOutput("gap cycle enable", mem_enable_o, 1'b0);
                gapPending = 0;
            end
            if (p0_ack_o || p1_ack_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected ack", {p1_ack_o, p0_ack_o}, 2'b00);
                end else begin
                    t = expQ.pop_front();
                    checkOutput("ack port", {p1_ack_o, p0_ack_o}, onehot(t.port));
                    checkOutput("grant at ack", grant_o, onehot(t.port));
                    checkOutput("mem addr", mem_addr_o, t.addr);
                    checkOutput("mem write", mem_write_o, t.write);
                    checkOutput("ack latency", busyCycles, MEM_LAT);
                    checkOutput("ungranted data", (t.port == 0) ? p1_data_o : p0_data_o, '0);
                    if (t.write) begin
                        checkOutput("write line", mem_data_o, t.data);
                        refMem[t.addr[10:5]] = t.data;
                    end else begin
                        checkOutput("read line", (t.port == 0) ? p0_data_o : p1_data_o,
                                    refMem[t.addr[10:5]]);
                    end
                    lastServed = t.port;
                    gapPending = 1;
                end
            end
        end
    end

    task automatic driveTxn(input expTxn_t t);
        if (t.port == 0) begin
            p0_enable_i = 1'b1; p0_write_i = t.write; p0_addr_i = t.addr; p0_data_i = t.data;
        end else begin
            p1_enable_i = 1'b1; p1_write_i = t.write; p1_addr_i = t.addr; p1_data_i = t.data;
        end
    endtask

    // Holds enables until acked; optionally re-raises p1 during GAP to contend with a waiting p0.
    task automatic waitDone(input int rereq1);
        int      budget = 0;
        int      left   = rereq1;
        bit      armed  = 0;
        expTxn_t t;
        while ((p0_enable_i || p1_enable_i || armed || expQ.size() != 0) && budget < MAX_WAIT) begin
            @(negedge clk_i);
            budget++;
            if (armed) begin
                armed = 0;
                t = makeTxn(1);
                driveTxn(t);
                if (p0_enable_i && winnerOf() == 1) expQ.push_front(t);
                else                                expQ.push_back(t);
            end
            if (p0_ack_o) p0_enable_i = 1'b0;
            if (p1_ack_o) begin
                p1_enable_i = 1'b0;
                if (left > 0) begin
                    left--;
                    armed = 1;
                end
            end
        end
        checkOutput("round completes in budget", budget < MAX_WAIT, 1'b1);
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input bit req0, input bit req1, input expTxn_t t0,
                                 input expTxn_t t1, input int rereq1);
        if (req0) driveTxn(t0);
        if (req1) driveTxn(t1);
        if (req0 && req1) begin
            if (winnerOf() == 1) begin expQ.push_back(t1); expQ.push_back(t0); end
            else                 begin expQ.push_back(t0); expQ.push_back(t1); end
        end else if (req0) begin
            expQ.push_back(t0);
        end else begin
            expQ.push_back(t1);
        end
        @(negedge clk_i);
        checkOutput("enable after request edge", mem_enable_o, 1'b1);
        checkOutput("first grant", grant_o, onehot(expQ[0].port));
        checkOutput("latched addr", mem_addr_o, expQ[0].addr);
        checkOutput("latched write", mem_write_o, expQ[0].write);
        waitDone(rereq1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " mem_enable"}, mem_enable_o, 1'b0);
        checkOutput({tag, " mem_write"}, mem_write_o, 1'b0);
        checkOutput({tag, " mem_addr"}, mem_addr_o, '0);
        checkOutput({tag, " mem_data"}, mem_data_o, '0);
        checkOutput({tag, " grant"}, grant_o, 2'b00);
        checkOutput({tag, " acks"}, {p1_ack_o, p0_ack_o}, 2'b00);
        checkOutput({tag, " data outs"}, p0_data_o | p1_data_o, '0);
    endtask

    initial begin
        expTxn_t t0, t1;
        int      pat;
        rst_i = 1'b0; glitchAck = 1'b0; modelData = '0;
        p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
        p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        repeat (3) @(negedge clk_i);
        checkAllZero("power-on reset");
        rst_i = 1'b1;
        @(negedge clk_i);

        $display("[TB] simultaneous p0 read 0x000 / p1 write 0x400");
        t0 = '{port: 0, write: 1'b0, addr: 32'h000, data: '0};
        t1 = '{port: 1, write: 1'b1, addr: 32'h400, data: {16{16'hECFA}}};
        applyStimulus(1'b1, 1'b1, t0, t1, 0);

        $display("[TB] two back-to-back conflicts");
        for (int i = 0; i < 2; i++) begin
            t0 = makeTxn(0); t0.write = 1'b0;
            t1 = makeTxn(1); t1.write = 1'b0;
            applyStimulus(1'b1, 1'b1, t0, t1, 0);
        end

        $display("[TB] lone p1 read of 0x200");
        t1 = '{port: 1, write: 1'b0, addr: 32'h200, data: '0};
        applyStimulus(1'b0, 1'b1, t0, t1, 0);

        $display("[TB] conflict with p1 re-requesting while p0 waits");
        applyStimulus(1'b1, 1'b1, makeTxn(0), makeTxn(1), 2);

        $display("[TB] memory ack glitch while idle");
        glitchAck = 1'b1;
        #1;
        checkOutput("glitch acks", {p1_ack_o, p0_ack_o}, 2'b00);
        @(negedge clk_i);
        glitchAck = 1'b0;
        checkOutput("glitch enable", mem_enable_o, 1'b0);
        checkOutput("glitch grant", grant_o, 2'b00);

        $display("[TB] p1 drops enable mid-transaction");
        t1 = makeTxn(1); t1.write = 1'b0;
        driveTxn(t1);
        expQ.push_back(t1);
        repeat (3) @(negedge clk_i);
        checkOutput("busy before drop", mem_enable_o, 1'b1);
        p1_enable_i = 1'b0; p1_addr_i = 32'hFFFF_FFE0; p1_write_i = 1'b1;
        t0 = makeTxn(0);
        driveTxn(t0);
        expQ.push_back(t0);
        @(negedge clk_i);
        checkOutput("latched addr after drop", mem_addr_o, t1.addr);
        waitDone(0);

        $display("[TB] reset during BUSY");
        t1 = makeTxn(1); t1.write = 1'b1; t1.addr = 32'h400;
        driveTxn(t1);
        expQ.push_back(t1);
        repeat (4) @(negedge clk_i);
        checkOutput("busy before reset", mem_enable_o, 1'b1);
        rst_i = 1'b0;
        #1;
        checkAllZero("mid-busy reset");
        expQ.delete();
        p1_enable_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, makeTxn(0), t1, 0);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 12; r++) begin
            pat = int'($urandom_range(0, 2));
            applyStimulus(pat != 1, pat != 0, makeTxn(0), makeTxn(1),
                          (pat != 0) ? int'($urandom_range(0, 1)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 SHALL have parameter DATA_W, default 256, the cache-line width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports p0_enable_i/p1_enable_i, input, 1, request from port 0 (I-side) / port 1 (D-cache); held high until that port's ack.
REQ-006 SHALL have ports p0_write_i/p1_write_i, input, 1: 1 = line write, 0 = line read.
REQ-007 SHALL have ports p0_addr_i/p1_addr_i, input, ADDR_W, the line address.
REQ-008 SHALL have ports p0_data_i/p1_data_i, input, DATA_W, the write-back line.
REQ-009 SHALL have ports p0_ack_o/p1_ack_o, output, 1, the one-cycle completion pulse.
REQ-010 SHALL have ports p0_data_o/p1_data_o, output, DATA_W, the read line; valid only with the matching ack.
REQ-011 SHALL have ports mem_enable_o, mem_write_o, output, 1, the memory request and direction.
REQ-012 SHALL have ports mem_addr_o (ADDR_W) and mem_data_o (DATA_W), output, the latched request.
REQ-013 SHALL have ports mem_ack_i, input, 1, and mem_data_i, input, DATA_W, the memory completion and read data.
REQ-014 SHALL have port grant_o, output, 2, one-hot owner of the memory: bit0 = p0, bit1 = p1, 00 = idle.

Function
REQ-015 FSM states SHALL be IDLE, BUSY and GAP.
- IDLE: if any enable is sampled high, pick a winner, latch its write/addr/data, and go to BUSY.
- BUSY: mem_enable_o = 1, outputs held stable; on mem_ack_i go to GAP.
- GAP: one cycle with mem_enable_o = 0, then IDLE.
REQ-016 Latency: a request sampled at edge N SHALL drive mem_enable_o high from edge N (registered output); a memory ack at cycle M SHALL give the requester's ack in cycle M.
REQ-017 pX_ack_o SHALL equal mem_ack_i AND (state == BUSY) AND grant_o[X], combinationally; the non-granted ack SHALL stay 0.
REQ-018 pX_data_o SHALL pass mem_data_i when grant_o[X] is set, and otherwise be 0.
REQ-019 Simultaneous requests in IDLE SHALL be resolved per REQ-026/027; the loser keeps its enable high and is served after GAP.
REQ-020 A request dropped during BUSY SHALL still be completed on memory and its ack pulsed; no abort path.
REQ-021 Requester inputs SHALL be ignored outside IDLE; the latched copies drive the memory port.
REQ-022 mem_ack_i in IDLE or GAP SHALL be ignored, with no ack forwarded.

Reset
REQ-023 Asserting rst_i low at any time, including mid-BUSY, SHALL immediately force state IDLE, mem_enable_o 0, mem_write_o 0, mem_addr_o 0, mem_data_o 0, grant_o 00, both acks 0 and both data_o 0.
REQ-024 After reset, the round-robin pointer SHALL favour p1 first.
REQ-025 A memory transaction cut off by reset SHALL be abandoned; the memory is reset by the same rst_i.

Configuration
REQ-026 With MEM_ARB_ROUND_ROBIN_EN defined, a simultaneous request SHALL grant the port not granted last; a last-grant flop updates on every grant.
REQ-027 Without MEM_ARB_ROUND_ROBIN_EN, p1 (D-cache) SHALL always win; the last-grant flop SHALL not exist.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY/GAP), the port index constants P0 = 0 and P1 = 1, and the defaults of ADDR_W and DATA_W.
REQ-029 Winner selection SHALL live in combinational sub-module mem_arb_pick (inputs: two requests and last grant; output: one-hot grant); all sequencing stays in mem_arbiter.

Verification
REQ-030 Bench SHALL use a memory model with 10-cycle ack latency and cover these scenarios:
- p1 read of addr 0x200 alone -> mem_addr_o = 0x200, mem_write_o = 0; p1_ack_o pulses 10 cycles after mem_enable_o rises; p1_data_o = memory line 16; p0_ack_o stays 0.
- p0 read 0x000 and p1 write 0x400 (data 0xECFA...) in the same cycle -> round-robin: p1 first, then after one GAP cycle p0; fixed: p1 first regardless of history.
- Two back-to-back conflicts with MEM_ARB_ROUND_ROBIN_EN -> order is p1, p0, p1, p0; p0 is never starved.
- p1 drops its enable 3 cycles into BUSY -> memory still completes and ack is pulsed; the next grant waits for GAP.
- rst_i low 4 cycles into BUSY -> all outputs 0 at once, grant_o = 00; a fresh p0 request after release is served normally.
- mem_ack_i glitch injected in IDLE -> no pX_ack_o and no state change.
